// File: rtl/muldiv_if.sv
// Issue/result handshake bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;
    logic [2:0]      md_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_val;

    modport master (
        output in_valid, a_val, b_val, md_sel, out_ready,
        input  in_ready, out_valid, out_val
    );

    modport slave (
        input  in_valid, a_val, b_val, md_sel, out_ready,
        output in_ready, out_valid, out_val
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 multiplier.
//
// state | meaning
// IDLE  | ready for a request; operands latched on accept
// BUSY  | 32 iterations, counter 31..0
// FIXUP | sign correction of the raw magnitude result
// DONE  | result presented, held until out_ready
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    state_t            state, state_nx;
    logic [4:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   res;
    logic [2:0]        op;
    logic              neg_res;
    logic              neg_rem;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast_mul, short_op;
    logic [XLEN-1:0]   short_val;

    always_comb begin
        is_div   = bus.md_sel[2];
        a_sgn    = (bus.md_sel == 3'd1) || (bus.md_sel == 3'd2) ||
                   (bus.md_sel == 3'd4) || (bus.md_sel == 3'd6);
        b_sgn    = (bus.md_sel == 3'd1) || (bus.md_sel == 3'd4) || (bus.md_sel == 3'd6);
        a_neg    = a_sgn & bus.a_val[XLEN-1];
        b_neg    = b_sgn & bus.b_val[XLEN-1];
        a_mag    = a_neg ? -bus.a_val : bus.a_val;
        b_mag    = b_neg ? -bus.b_val : bus.b_val;
        div_zero = is_div && (bus.b_val == '0);
        div_ovf  = ((bus.md_sel == 3'd4) || (bus.md_sel == 3'd6)) &&
                   (bus.a_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_val == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
    assign fast_prod = $signed({a_sgn & bus.a_val[XLEN-1], bus.a_val}) *
                       $signed({b_sgn & bus.b_val[XLEN-1], bus.b_val});
    assign fast_mul  = !is_div;
`else
    assign fast_mul  = 1'b0;
`endif

    always_comb begin
        short_val = '0;
        if (div_zero)
            short_val = bus.md_sel[1] ? bus.a_val : '1;
        else if (div_ovf)
            short_val = bus.md_sel[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
        else if (fast_mul)
            short_val = (bus.md_sel == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
        short_op = div_zero | div_ovf | fast_mul;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix   = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'd0:          fix_val = prod_fix[XLEN-1:0];
            3'd4, 3'd5:    fix_val = quo_fix;
            3'd6, 3'd7:    fix_val = rem_fix;
            default:       fix_val = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = short_op ? DONE : BUSY;
            BUSY:    if (count == 5'd0) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_val   = res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 5'd0;
            acc     <= '0;
            opnd    <= '0;
            res     <= '0;
            op      <= 3'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    op      <= bus.md_sel;
                    count   <= 5'd31;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    acc     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                    opnd    <= is_div ? b_mag : a_mag;
                    if (short_op) res <= short_val;
                end
                BUSY: begin
                    acc   <= op[2] ? div_step : mul_step;
                    count <= count - 5'd1;
                end
                FIXUP:   res <= fix_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results from 64-bit arithmetic, latency from the handshake.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 1;
        if (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    // Drive one request, push its expectation, then scramble the operand bus after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.val = model(op, a, b);
        e.lat = lat_of(op, a, b);
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.md_sel   = op;
        bus.a_val    = a;
        bus.b_val    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a_val    = $urandom;
        bus.b_val    = $urandom;
        bus.md_sel   = 3'($urandom_range(0, 7));
    endtask

    task automatic collect(output logic [31:0] val, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
        val = bus.out_val;
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid=0 required 1 within %0d cycles", lat);
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks += 3;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b required 0", bus.out_valid); end
        if (bus.out_val !== 32'd0) begin n_fail++; $display("FAIL reset out_val: got %h required 0", bus.out_val); end
    endtask

    task automatic test_mul();
        req_t        reqs[$];
        logic [31:0] got;
        int          lat;
        exp_t        e;
        reqs.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD});
        reqs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000});
        reqs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        reqs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        reqs.push_back('{3'd1, 32'hFFFF_FFFB, 32'd3});
        reqs.push_back('{3'd2, 32'h1234_5678, 32'h8765_4321});
        reqs.push_back('{3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D});
        foreach (reqs[i]) begin
            issue(reqs[i].op, reqs[i].a, reqs[i].b);
            collect(got, lat);
            e = exp_q.pop_front();
            n_checks += 2;
            if (got !== e.val) begin n_fail++; $display("FAIL mul[%0d] value: got %h required %h", i, got, e.val); end
            if (lat != e.lat) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d required %0d", i, lat, e.lat); end
            release_result();
        end
    endtask

    task automatic test_div();
        req_t        reqs[$];
        logic [31:0] got;
        int          lat;
        exp_t        e;
        reqs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2});
        reqs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2});
        reqs.push_back('{3'd5, 32'd100, 32'd7});
        reqs.push_back('{3'd7, 32'd100, 32'd7});
        reqs.push_back('{3'd4, 32'd7, 32'hFFFF_FFFE});
        reqs.push_back('{3'd6, 32'd7, 32'hFFFF_FFFE});
        reqs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd1});
        reqs.push_back('{3'd4, 32'h8000_0000, 32'd1});
        foreach (reqs[i]) begin
            issue(reqs[i].op, reqs[i].a, reqs[i].b);
            collect(got, lat);
            e = exp_q.pop_front();
            n_checks += 2;
            if (got !== e.val) begin n_fail++; $display("FAIL div[%0d] value: got %h required %h", i, got, e.val); end
            if (lat != e.lat) begin n_fail++; $display("FAIL div[%0d] latency: got %0d required %0d", i, lat, e.lat); end
            release_result();
        end
    endtask

    task automatic test_boundary();
        req_t        reqs[$];
        logic [31:0] got;
        int          lat;
        exp_t        e;
        reqs.push_back('{3'd5, 32'd5, 32'd0});
        reqs.push_back('{3'd6, 32'd5, 32'd0});
        reqs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF});
        reqs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF});
        reqs.push_back('{3'd4, 32'd0, 32'd0});
        reqs.push_back('{3'd7, 32'hCAFE_0001, 32'd0});
        reqs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF});
        foreach (reqs[i]) begin
            issue(reqs[i].op, reqs[i].a, reqs[i].b);
            collect(got, lat);
            e = exp_q.pop_front();
            n_checks += 2;
            if (got !== e.val) begin n_fail++; $display("FAIL boundary[%0d] value: got %h required %h", i, got, e.val); end
            if (lat != e.lat) begin n_fail++; $display("FAIL boundary[%0d] latency: got %0d required %0d", i, lat, e.lat); end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, a, b;
        logic [2:0]  op;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            issue(op, a, b);
            collect(got, lat);
            e = exp_q.pop_front();
            n_checks += 2;
            if (got !== e.val) begin n_fail++; $display("FAIL b2b[%0d] op%0d a=%h b=%h value: got %h required %h", i, op, a, b, got, e.val); end
            if (lat != e.lat) begin n_fail++; $display("FAIL b2b[%0d] latency: got %0d required %0d", i, lat, e.lat); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, held;
        int          lat;
        exp_t        e, e2;
        issue(3'd0, 32'd12345, 32'd678);
        collect(got, lat);
        e = exp_q.pop_front();
        held = e.val;
        n_checks++;
        if (got !== e.val) begin n_fail++; $display("FAIL bp first value: got %h required %h", got, e.val); end
        e2.val = model(3'd5, 32'd1000, 32'd3);
        e2.lat = lat_of(3'd5, 32'd1000, 32'd3);
        exp_q.push_back(e2);
        bus.in_valid = 1'b1;
        bus.md_sel   = 3'd5;
        bus.a_val    = 32'd1000;
        bus.b_val    = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks += 3;
            if (bus.out_val !== held) begin n_fail++; $display("FAIL bp[%0d] out_val: got %h required %h", i, bus.out_val, held); end
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp[%0d] in_ready: got %b required 0", i, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp[%0d] out_valid: got %b required 1", i, bus.out_valid); end
        end
        release_result();
        n_checks += 2;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release out_valid: got %b required 0", bus.out_valid); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp accept in_ready: got %b required 0", bus.in_ready); end
        collect(got, lat);
        e = exp_q.pop_front();
        n_checks += 2;
        if (got !== e.val) begin n_fail++; $display("FAIL bp second value: got %h required %h", got, e.val); end
        if (lat != e.lat) begin n_fail++; $display("FAIL bp second latency: got %0d required %0d", lat, e.lat); end
        release_result();
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.md_sel   = 3'd4;
        bus.a_val    = 32'd1000;
        bus.b_val    = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort busy in_ready: got %b required 0", bus.in_ready); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks += 3;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort in_ready: got %b required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort out_valid: got %b required 0", bus.out_valid); end
        if (bus.out_val !== 32'd0) begin n_fail++; $display("FAIL abort out_val: got %h required 0", bus.out_val); end
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort stale result: out_valid seen %b required 0", seen); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_val     = 32'd0;
        bus.b_val     = 32'd0;
        bus.md_sel    = 3'd0;
        rst           = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
